conv1d_output_packer: RTL and testbench
=======================================

// Module: conv1d_output_packer
// PURPOSE
//  Downstream of the conv1d CFU stage: accepts one quantized int8 result per handshake (a cmd-7 readback).
//  Optional 2:1 temporal max-pool; packs bytes little-endian into 32-bit words (first byte -> [7:0]).
//  Buffers words in a FIFO the CPU drains 4 values per read, matching the 4-at-once buffer write format.
// PARAMETERS
//  BYTE_SIZE     8    width of one quantized value
//  INT32_SIZE    32   packed word width
//  FIFO_DEPTH    64   words held in output FIFO (power of 2)
//  MAX_CHANNELS  128  max output channels per row (pool line buffer size)
// PORTS
//  clk           in   1                        clock, all logic on posedge
//  reset_n       in   1                        asynchronous, active-low reset
//  clear         in   1                        sync clear of packer, FIFO, pool state
//  flush         in   1                        1-cycle pulse: emit partial word, zero-padded
//  cfg_channels  in   8                        channels per output row (pool row length)
//  in_valid      in   1                        in_data valid
//  in_ready      out  1                        block accepts in_data this cycle
//  in_data       in   BYTE_SIZE                signed quantized value
//  out_valid     out  1                        FIFO non-empty
//  out_ready     in   1                        consumer pops word this cycle
//  out_data      out  INT32_SIZE               FIFO head word
//  fill_level    out  $clog2(FIFO_DEPTH)+1     words in FIFO
//  flush_done    out  1                        1-cycle pulse when flush complete
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_data=0, fill_level=0, flush_done=0; state ST_RUN, byte_cnt=0, parity=0, ch_cnt=0.
//  Handshakes: transfer when valid&&ready, both sides; in_ready has no combinational path from out_ready.
//  Packer: 3-byte holding reg + byte_cnt (0..3); 4th accepted byte forms a word written to FIFO in the same cycle.
//  in_ready = (state==ST_RUN) && !(byte_cnt==3 && fifo_full); full taken from the registered count.
//  FIFO: push and pop in the same cycle allowed when neither full nor empty; fill_level unchanged.
//  When full, push only after a pop has registered (no bypass). Push-to-out_valid latency is 1 cycle.
//  out_data is the registered head; it holds while out_valid && !out_ready.
//  States:
//    ST_RUN   -> ST_FLUSH on flush.
//    ST_FLUSH: in_ready=0.
//      byte_cnt==0: flush_done, back to ST_RUN next cycle.
//      else: when !fifo_full, push {zero pad, held bytes}, byte_cnt=0, flush_done, -> ST_RUN.
//  flush arriving in the same cycle as an accepted byte: the byte is packed first, then the flush proceeds.
//  clear overrides everything in its cycle: FIFO emptied, byte_cnt/ch_cnt/parity=0, state ST_RUN, flush_done=0.
//  clear does not rewrite FIFO RAM contents.
//  Bytes are never reordered or dropped; the FIFO wraps its pointers modulo FIFO_DEPTH.
// CONFIGURATION
//  CONV1D_OUT_POOL_EN defined:
//    2:1 max-pool over time using line buffer pool_mem[MAX_CHANNELS].
//    ch_cnt counts accepted bytes 0..cfg_channels-1; at cfg_channels-1 it wraps to 0 and toggles parity.
//    parity=0: byte stored in pool_mem[ch_cnt], not forwarded to packer.
//    parity=1: forward signed max(pool_mem[ch_cnt], in_data) to packer in the accept cycle.
//    in_ready also requires packer space on parity=1.
//    cfg_channels==0: pool bypassed, pass-through. cfg_channels is sampled only while ch_cnt==0 && parity==0.
//    flush does not reset parity/ch_cnt; clear does.
//  CONV1D_OUT_POOL_EN undefined:
//    every accepted byte goes straight to the packer; cfg_channels ignored; no pool_mem inferred.
// STRUCTURE
//  Package conv1d_pkg: BYTE_SIZE/INT32_SIZE localparams, state enum {ST_RUN, ST_FLUSH}, and the pack-word typedef.
//  Sub-module conv1d_word_fifo: sync FIFO, block-RAM style, registered read, count output.
//  The packer, flush FSM and pool logic stay in this module.
// TESTING
//  1. Push 8'h01,02,03,04,05,06,07,08, out_ready=1 -> words 32'h04030201 then 32'h08070605, fill_level returns to 0.
//  2. Push 8'hAA,BB then flush -> one word 32'h0000BBAA, flush_done pulses once, in_ready low only during ST_FLUSH.
//  3. out_ready=0, push 4*FIFO_DEPTH+3 bytes -> fill_level=64, in_ready=0 at byte_cnt=3.
//     Then pop one -> in_ready=1 next cycle, no byte lost or duplicated.
//  4. Assert reset_n=0 mid-stream with byte_cnt=2, fill_level=5 -> all outputs at reset values immediately.
//     After release, first 4 bytes form a fresh word.
//  5. clear together with in_valid and out_ready -> FIFO empty, byte_cnt=0, the accepted byte is discarded.
//  6. POOL_EN, cfg_channels=2:
//     rows {-5,3} then {2,-7} -> packer receives 8'h02,8'h03; no output after the first row.
//     Without POOL_EN -> FB,03,02,F9 = 32'hF90203FB.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared types and constants for the conv1d output packer and its word FIFO.
package conv1d_pkg;

  localparam int unsigned BYTE_SIZE  = 8;
  localparam int unsigned INT32_SIZE = 32;
  localparam int unsigned HOLD_BYTES = 3;
  localparam int unsigned HOLD_W     = HOLD_BYTES * BYTE_SIZE;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Packed output word, b0 is the first byte received (little-endian).
  typedef struct packed {
    logic [BYTE_SIZE-1:0] b3;
    logic [BYTE_SIZE-1:0] b2;
    logic [BYTE_SIZE-1:0] b1;
    logic [BYTE_SIZE-1:0] b0;
  } pack_word_t;

  // Build a partial word from the first cnt held bytes, upper bytes zero.
  function automatic pack_word_t pad_word(input logic [HOLD_W-1:0] hold,
                                          input logic [1:0]        cnt);
    pack_word_t w;
    w = '0;
    if (cnt >= 2'd1) w.b0 = hold[0 +: BYTE_SIZE];
    if (cnt >= 2'd2) w.b1 = hold[BYTE_SIZE +: BYTE_SIZE];
    if (cnt == 2'd3) w.b2 = hold[2*BYTE_SIZE +: BYTE_SIZE];
    return w;
  endfunction

endpackage

// File: rtl/conv1d_word_fifo.sv
// Synchronous word FIFO: RAM storage, registered head output, occupancy count.
module conv1d_word_fifo
  import conv1d_pkg::*;
#(
  parameter int unsigned WIDTH = INT32_SIZE,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;
  logic             bypass;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = head_q;

  // A push lands directly in the head register when it becomes the next head.
  assign bypass = push_ok && ((count_q == '0) ||
                              ((count_q == CNT_W'(1)) && pop_ok));

  // Next pointers, count and head value.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_d   = bypass ? wdata_i : mem[rd_ptr_d];
  end

  // Storage array write port (not reset, not touched by clear).
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem[wr_ptr_q] <= wdata_i;
  end

  // Pointer, count and registered head state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/conv1d_output_packer.sv
// conv1d output packer: optional 2:1 temporal max-pool, little-endian byte
// packing into 32-bit words, flush of partial words, and an output word FIFO.
// Build option: define CONV1D_OUT_POOL_EN to enable the max-pool line buffer.
module conv1d_output_packer
  import conv1d_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned MAX_CHANNELS = 128
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          flush,
  input  logic [7:0]                    cfg_channels,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BYTE_SIZE-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT32_SIZE-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          flush_done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 flush_done_q, flush_done_d;

  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 push;
  pack_word_t           push_word;

  logic                 in_fire;
  logic                 pk_need;
  logic                 pk_valid;
  logic [BYTE_SIZE-1:0] pk_byte;

  // Packer space is only needed when the accepted byte actually reaches it.
  assign in_ready = (state_q == ST_RUN) &&
                    !(pk_need && (byte_cnt_q == 2'd3) && fifo_full);
  assign in_fire  = in_valid && in_ready;

`ifdef CONV1D_OUT_POOL_EN
  localparam int unsigned CH_IDX_W = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

  logic [BYTE_SIZE-1:0] pool_mem [MAX_CHANNELS];
  logic [7:0]           ch_cnt_q, ch_cnt_d;
  logic                 parity_q, parity_d;
  logic [7:0]           cfg_q;
  logic [7:0]           cfg_eff;
  logic                 row_start;
  logic                 pool_bypass;
  logic [BYTE_SIZE-1:0] pool_old;

  // Row length is latched only at the start of a row pair.
  assign row_start   = (ch_cnt_q == 8'd0) && !parity_q;
  assign cfg_eff     = row_start ? cfg_channels : cfg_q;
  assign pool_bypass = (cfg_eff == 8'd0);
  assign pool_old    = pool_mem[CH_IDX_W'(ch_cnt_q)];
  assign pk_need     = pool_bypass || parity_q;

  // Pool routing: even rows fill the line buffer, odd rows emit the max.
  always_comb begin
    pk_valid = 1'b0;
    pk_byte  = in_data;
    ch_cnt_d = ch_cnt_q;
    parity_d = parity_q;
    if (in_fire) begin
      if (pool_bypass) begin
        pk_valid = 1'b1;
      end else begin
        if (parity_q) begin
          pk_valid = 1'b1;
          pk_byte  = ($signed(pool_old) > $signed(in_data)) ? pool_old : in_data;
        end
        if (ch_cnt_q == (cfg_eff - 8'd1)) begin
          ch_cnt_d = 8'd0;
          parity_d = !parity_q;
        end else begin
          ch_cnt_d = ch_cnt_q + 8'd1;
        end
      end
    end
  end

  // Line buffer write on the even row of each pair.
  always_ff @(posedge clk) begin
    if (in_fire && !clear && !pool_bypass && !parity_q)
      pool_mem[CH_IDX_W'(ch_cnt_q)] <= in_data;
  end

  // Pool position and latched row length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt_q <= 8'd0;
      parity_q <= 1'b0;
      cfg_q    <= 8'd0;
    end else if (clear) begin
      ch_cnt_q <= 8'd0;
      parity_q <= 1'b0;
      cfg_q    <= 8'd0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      parity_q <= parity_d;
      if (row_start) cfg_q <= cfg_channels;
    end
  end
`else
  logic unused_pool_cfg;

  assign unused_pool_cfg = ^{cfg_channels, 8'(MAX_CHANNELS)};
  assign pk_need         = 1'b1;
  assign pk_valid        = in_fire;
  assign pk_byte         = in_data;
`endif

  // Packer and flush FSM: next state, holding register and FIFO push.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    hold_d       = hold_q;
    flush_done_d = 1'b0;
    push         = 1'b0;
    push_word    = '0;
    case (state_q)
      ST_RUN: begin
        if (pk_valid) begin
          if (byte_cnt_q == 2'd3) begin
            push      = 1'b1;
            push_word = '{b3: pk_byte,
                          b2: hold_q[2*BYTE_SIZE +: BYTE_SIZE],
                          b1: hold_q[BYTE_SIZE +: BYTE_SIZE],
                          b0: hold_q[0 +: BYTE_SIZE]};
            byte_cnt_d = 2'd0;
          end else begin
            case (byte_cnt_q)
              2'd0:    hold_d[0 +: BYTE_SIZE]           = pk_byte;
              2'd1:    hold_d[BYTE_SIZE +: BYTE_SIZE]   = pk_byte;
              default: hold_d[2*BYTE_SIZE +: BYTE_SIZE] = pk_byte;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (byte_cnt_q == 2'd0) begin
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end else if (!fifo_full) begin
          push         = 1'b1;
          push_word    = pad_word(hold_q, byte_cnt_q);
          byte_cnt_d   = 2'd0;
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Packer and FSM state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      byte_cnt_q   <= 2'd0;
      hold_q       <= '0;
      flush_done_q <= 1'b0;
    end else if (clear) begin
      state_q      <= ST_RUN;
      byte_cnt_q   <= 2'd0;
      hold_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      hold_q       <= hold_d;
      flush_done_q <= flush_done_d;
    end
  end

  conv1d_word_fifo #(
    .WIDTH (INT32_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (out_ready),
    .rdata_o (out_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign fill_level = fifo_count;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_conv1d_output_packer.sv
// Directed bench for conv1d_output_packer: packing table, flush, full FIFO,
// async reset, clear and the pooling row example.
module tb_conv1d_output_packer;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        flush;
  logic [7:0]  cfg_channels;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [6:0]  fill_level;
  logic        flush_done;

  int n_cmp = 0;
  int n_err = 0;

  conv1d_output_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .flush        (flush),
    .cfg_channels (cfg_channels),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fill_level   (fill_level),
    .flush_done   (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at %b for byte %h", in_ready, b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for a word (bounded), check it, and pop it.
  task automatic pop_word(input logic [31:0] exp, input string name);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    reset_n      = 1'b0;
    clear        = 1'b0;
    flush        = 1'b0;
    cfg_channels = 8'd0;
    in_valid     = 1'b0;
    in_data      = 8'd0;
    out_ready    = 1'b0;

    vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
    vecs[1] = '{8'h05, 8'h06, 8'h07, 8'h08, 32'h08070605};
    vecs[2] = '{8'hFF, 8'h80, 8'h7F, 8'h00, 32'h007F80FF};
    vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h01000000};

    repeat (3) tick();
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   out_data,        32'd0);
    check("rst_fill_level", 32'(fill_level), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Packing table
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      send_byte(vecs[i].b3);
      check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'd1);
      pop_word(vecs[i].exp, $sformatf("vec%0d_word", i));
    end
    check("vec_fill_empty", 32'(fill_level), 32'd0);

    // Partial word flush
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_flush();
    check("flush_in_ready_low", 32'(in_ready), 32'd0);
    check("flush_done_early", 32'(flush_done), 32'd0);
    tick();
    check("flush_done_pulse", 32'(flush_done), 32'd1);
    check("flush_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("flush_done_single", 32'(flush_done), 32'd0);
    pop_word(32'h0000BBAA, "flush_word");

    // Flush with nothing held
    pulse_flush();
    tick();
    check("flush_empty_done", 32'(flush_done), 32'd1);
    check("flush_empty_no_word", 32'(out_valid), 32'd0);
    tick();

    // Fill the FIFO completely plus three held bytes
    for (int i = 0; i < 4 * 64 + 3; i++) send_byte(8'(i));
    check("full_fill_level", 32'(fill_level), 32'd64);
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h03;
    tick();
    check("full_still_blocked", 32'(in_ready), 32'd0);
    check("full_head_word", out_data, 32'h03020100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_ready_after_pop", 32'(in_ready), 32'd1);
    check("full_fill_after_pop", 32'(fill_level), 32'd63);
    tick();
    in_valid = 1'b0;
    check("full_refilled", 32'(fill_level), 32'd64);
    for (int k = 1; k <= 64; k++) begin
      w = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
      pop_word(w, $sformatf("drain%0d", k));
    end
    check("drain_empty", 32'(fill_level), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 22; i++) send_byte(8'h50 + 8'(i));
    check("pre_rst_fill", 32'(fill_level), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_in_ready",   32'(in_ready),   32'd1);
    check("arst_out_valid",  32'(out_valid),  32'd0);
    check("arst_out_data",   out_data,        32'd0);
    check("arst_fill_level", 32'(fill_level), 32'd0);
    check("arst_flush_done", 32'(flush_done), 32'd0);
    reset_n = 1'b1;
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    pop_word(32'h44332211, "post_rst_word");

    // Clear with simultaneous input and pop
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_fill_level", 32'(fill_level), 32'd0);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    check("clr_fill_one", 32'(fill_level), 32'd1);
    pop_word(32'h40302010, "clr_fresh_word");

    // Two rows of two channels
    cfg_channels = 8'd2;
    send_byte(8'hFB);
    send_byte(8'h03);
    check("pool_row1_no_out", 32'(out_valid), 32'd0);
    send_byte(8'h02);
    send_byte(8'hF9);
`ifdef CONV1D_OUT_POOL_EN
    check("pool_row2_no_word", 32'(out_valid), 32'd0);
    pulse_flush();
    tick();
    check("pool_flush_done", 32'(flush_done), 32'd1);
    pop_word(32'h00000302, "pool_word");
`else
    pop_word(32'hF90203FB, "nopool_word");
`endif
    cfg_channels = 8'd0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
